// File: rtl/data_log_core.sv
// data_log_core: buffers one serial command line and decodes it to a 4-bit code on CR (DATA_LOG_LF_TERM_EN also accepts LF)
module data_log_core #(
  parameter int DATA_W    = 7,
  parameter int BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] datain,
  input  logic              newdata,
  output logic [3:0]        command_out
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [DATA_W-1:0] CH_CR = DATA_W'(8'h0D);
  localparam logic [DATA_W-1:0] CH_BS = DATA_W'(8'h08);
  localparam logic [DATA_W-1:0] CH_T  = DATA_W'(8'h74);
  localparam logic [DATA_W-1:0] CH_S  = DATA_W'(8'h73);
  localparam logic [DATA_W-1:0] CH_R  = DATA_W'(8'h72);
  localparam logic [DATA_W-1:0] CH_U  = DATA_W'(8'h75);
  localparam logic [DATA_W-1:0] CH_1  = DATA_W'(8'h31);
  localparam logic [DATA_W-1:0] CH_2  = DATA_W'(8'h32);
  logic              newdata_q;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [3:0]        cmd_q, cmd_d, dec;
  logic [DATA_W-1:0] line_q [BUF_DEPTH];
  logic [DATA_W-1:0] line_d [BUF_DEPTH];
  logic              accept, is_term;
  assign accept      = newdata & ~newdata_q;
  assign command_out = cmd_q;
`ifdef DATA_LOG_LF_TERM_EN
  assign is_term = (datain == CH_CR) || (datain == DATA_W'(8'h0A));
`else
  assign is_term = datain == CH_CR;
`endif
  always_comb begin
    dec = 4'hF;
    if (!ovf_q && count_q == CW'(1))
      dec = line_q[0] == CH_R ? 4'h3 : line_q[0] == CH_U ? 4'h4 : 4'hF;
    else if (!ovf_q && count_q == CW'(2))
      dec = line_q[0] == CH_T && line_q[1] == CH_1 ? 4'h1 :
            line_q[0] == CH_T && line_q[1] == CH_2 ? 4'h2 :
            line_q[0] == CH_S && line_q[1] == CH_1 ? 4'h5 :
            line_q[0] == CH_S && line_q[1] == CH_2 ? 4'h6 : 4'hF;
  end
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    cmd_d   = cmd_q;
    line_d  = line_q;
    if (accept) begin
      if (is_term) begin
        if (count_q != '0 || ovf_q) begin
          cmd_d   = dec;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end else if (datain == CH_BS) begin
        count_d = count_q == '0 ? '0 : count_q - CW'(1);
        ovf_d   = count_d == '0 ? 1'b0 : ovf_q;
      end else if (count_q == CW'(BUF_DEPTH)) begin
        ovf_d = 1'b1;
      end else begin
        for (int i = 0; i < BUF_DEPTH; i++)
          if (CW'(i) == count_q) line_d[i] = datain;
        count_d = count_q + CW'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      newdata_q <= 1'b0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      cmd_q     <= 4'h0;
    end else begin
      newdata_q <= newdata;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      cmd_q     <= cmd_d;
      line_q    <= line_d;
    end
  end
endmodule

// File: tb/tb_data_log_core.sv
// tb_data_log_core: scoreboard bench for the command line parser
module tb_data_log_core;
  logic       clk = 1'b0, reset = 1'b1, newdata = 1'b0, probe = 1'b0;
  logic [6:0] datain = '0;
  logic [3:0] command_out;
  logic [3:0] exp_q [$];
  int         checks = 0, errors = 0;
  bit         pending = 0, prev_nd = 0;
  string      tag = "reset";
  localparam logic [6:0] CR = 7'h0D, LF = 7'h0A, BS = 7'h08, T = 7'h74, S = 7'h73, R = 7'h72,
                         U = 7'h75, X = 7'h78, D1 = 7'h31, D2 = 7'h32, D3 = 7'h33;
  always #5 clk = ~clk;
  data_log_core dut (
    .clk(clk),
    .reset(reset),
    .datain(datain),
    .newdata(newdata),
    .command_out(command_out)
  );
  function automatic bit term(logic [6:0] c);
`ifdef DATA_LOG_LF_TERM_EN
    return c == CR || c == LF;
`else
    return c == CR;
`endif
  endfunction
  task automatic cmp(string kind);
    logic [3:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s/%s: command_out=%h but nothing expected", tag, kind, command_out);
    end else begin
      e = exp_q.pop_front();
      if (command_out !== e) begin
        errors++;
        $display("FAIL %s/%s: command_out=%h expected %h", tag, kind, command_out, e);
      end
    end
  endtask
  always @(negedge clk) begin
    if (pending) begin
      pending = 0;
      cmp("term");
    end else if (probe) cmp("probe");
    if (newdata && !prev_nd && term(datain)) pending = 1;
    prev_nd = newdata;
  end
  task automatic send(input logic [6:0] c);
    @(posedge clk);
    #2 datain = c;
    newdata = 1'b1;
    repeat (2) @(posedge clk);
    #2 newdata = 1'b0;
    @(posedge clk);
  endtask
  task automatic finish_line(input logic [6:0] c, input logic [3:0] e);
    exp_q.push_back(e);
    send(c);
  endtask
  task automatic expect_now(input logic [3:0] e);
    exp_q.push_back(e);
    @(posedge clk);
    #2 probe = 1'b1;
    @(posedge clk);
    #2 probe = 1'b0;
  endtask
  task automatic pulse_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    expect_now(4'h0);
    tag = "t1";
    send(T); send(D1); finish_line(CR, 4'h1);
    repeat (3) @(posedge clk);
    expect_now(4'h1);
    tag = "t2";
    send(T); send(D2); finish_line(CR, 4'h2);
    tag = "bad_1";
    send(D1); finish_line(CR, 4'hF);
    tag = "reset_mid";
    send(T); pulse_reset();
    expect_now(4'h0);
    send(D1); finish_line(CR, 4'hF);
    tag = "reset_on_cr";
    send(T);
    exp_q.push_back(4'h0);
    @(posedge clk);
    #2 reset = 1'b1;
    datain = CR;
    newdata = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #2 newdata = 1'b0;
    @(posedge clk);
    expect_now(4'h0);
    tag = "overflow";
    repeat (5) send(X);
    finish_line(CR, 4'hF);
    tag = "s2";
    send(S); send(D2); finish_line(CR, 4'h6);
    tag = "backspace";
    send(T); send(D3); send(BS); send(D2); finish_line(CR, 4'h2);
    tag = "empty";
    finish_line(CR, 4'h2);
    tag = "long_strobe";
    @(posedge clk);
    #2 datain = U;
    newdata = 1'b1;
    repeat (10) @(posedge clk);
    #2 newdata = 1'b0;
    @(posedge clk);
    finish_line(CR, 4'h4);
    tag = "r";
    send(R); finish_line(CR, 4'h3);
    tag = "s1";
    send(S); send(D1); finish_line(CR, 4'h5);
    tag = "too_long";
    send(T); send(D1); send(D2); finish_line(CR, 4'hF);
    tag = "bs_floor";
    send(BS); send(BS); send(T); send(D1); finish_line(CR, 4'h1);
`ifdef DATA_LOG_LF_TERM_EN
    tag = "crlf";
    send(R); finish_line(CR, 4'h3); finish_line(LF, 4'h3);
    tag = "lf_u";
    send(U); finish_line(LF, 4'h4);
`else
    tag = "lf_char";
    send(R); send(LF); finish_line(CR, 4'hF);
`endif
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected values left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
